// File: rtl/tb_sim_ctrl_pkg.sv
// Shared types and constants for the simulation controller and its phase timer.
package tb_sim_ctrl_pkg;

    localparam int TIMER_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_ARM   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        STATUS_NONE     = 3'd0,
        STATUS_PASS     = 3'd1,
        STATUS_FAIL     = 3'd2,
        STATUS_EXIT_OK  = 3'd3,
        STATUS_EXIT_ERR = 3'd4,
        STATUS_TIMEOUT  = 3'd5
    } status_e;

    localparam logic [31:0] EXIT_CODE_PASS    = 32'd0;
    localparam logic [31:0] EXIT_CODE_FAIL    = 32'd1;
    localparam logic [31:0] EXIT_CODE_TIMEOUT = 32'hFFFF_FFFF;

    // A phase lasting N cycles loads N-1 so that it ends on the edge after the timer hits zero.
    function automatic logic [TIMER_W-1:0] phase_load(input int cycles);
        return (cycles > 0) ? TIMER_W'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/tb_sim_ctrl_timer.sv
// Loadable down-counter shared by the RESET, ARM and DRAIN phases.
module tb_phase_timer
    import tb_sim_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] value_i,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Timer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/tb_sim_ctrl.sv
// Simulation controller: sequences core reset and fetch enable, watches the
// pass/fail/exit indications and a cycle watchdog, latches one final status,
// drains for a few cycles and then raises a sticky done_o.
module tb_sim_ctrl
    import tb_sim_ctrl_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int FETCH_DELAY_CYCLES = 4,
    parameter int DRAIN_CYCLES       = 8,
    parameter int CNT_W              = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [CNT_W-1:0] max_cycles_i,
    input  logic             tests_passed_i,
    input  logic             tests_failed_i,
    input  logic             exit_valid_i,
    input  logic [31:0]      exit_value_i,
    output logic             core_rst_no,
    output logic             fetch_enable_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [2:0]       status_o,
    output logic [31:0]      exit_code_o,
    output logic             done_o
);

    state_e             state_q,       state_d;
    logic               core_rst_n_q,  core_rst_n_d;
    logic               fetch_en_q,    fetch_en_d;
    logic [CNT_W-1:0]   cycle_cnt_q,   cycle_cnt_d;
    status_e            status_q,      status_d;
    logic [31:0]        exit_code_q,   exit_code_d;
    logic               done_q,        done_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_zero;

    logic               ev_valid;
    status_e            ev_status;
    logic [31:0]        ev_code;

    tb_phase_timer u_timer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .load_i  (timer_load),
        .value_i (timer_value),
        .zero_o  (timer_zero)
    );

    // Priority encoder for terminating events; the watchdog sees the pre-increment count.
    always_comb begin
        ev_valid  = 1'b0;
        ev_status = STATUS_NONE;
        ev_code   = '0;
        if (tests_failed_i) begin
            ev_valid  = 1'b1;
            ev_status = STATUS_FAIL;
            ev_code   = EXIT_CODE_FAIL;
        end else if (exit_valid_i && (exit_value_i != '0)) begin
            ev_valid  = 1'b1;
            ev_status = STATUS_EXIT_ERR;
            ev_code   = exit_value_i;
        end else if (tests_passed_i) begin
            ev_valid  = 1'b1;
            ev_status = STATUS_PASS;
            ev_code   = EXIT_CODE_PASS;
        end else if (exit_valid_i) begin
            ev_valid  = 1'b1;
            ev_status = STATUS_EXIT_OK;
            ev_code   = exit_value_i;
        end else if ((max_cycles_i != '0) && (cycle_cnt_q == max_cycles_i)) begin
            ev_valid  = 1'b1;
            ev_status = STATUS_TIMEOUT;
            ev_code   = EXIT_CODE_TIMEOUT;
        end
    end

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        core_rst_n_d = core_rst_n_q;
        fetch_en_d   = fetch_en_q;
        cycle_cnt_d  = cycle_cnt_q;
        status_d     = status_q;
        exit_code_d  = exit_code_q;
        done_d       = done_q;
        timer_load   = 1'b0;
        timer_value  = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d      = ST_RESET;
                    core_rst_n_d = 1'b0;
                    timer_load   = 1'b1;
                    timer_value  = phase_load(RESET_HOLD_CYCLES);
                end
            end
            ST_RESET: begin
                if (timer_zero) begin
                    core_rst_n_d = 1'b1;
                    if (FETCH_DELAY_CYCLES == 0) begin
                        state_d    = ST_RUN;
                        fetch_en_d = 1'b1;
                    end else begin
                        state_d     = ST_ARM;
                        timer_load  = 1'b1;
                        timer_value = phase_load(FETCH_DELAY_CYCLES);
                    end
                end
            end
            ST_ARM: begin
                if (timer_zero) begin
                    state_d    = ST_RUN;
                    fetch_en_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (ev_valid) begin
                    status_d    = ev_status;
                    exit_code_d = ev_code;
                    fetch_en_d  = 1'b0;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = ST_DRAIN;
                        timer_load  = 1'b1;
                        timer_value = phase_load(DRAIN_CYCLES);
                    end
                end else if (cycle_cnt_q != {CNT_W{1'b1}}) begin
                    cycle_cnt_d = cycle_cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (timer_zero) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            core_rst_n_q <= 1'b0;
            fetch_en_q   <= 1'b0;
            cycle_cnt_q  <= '0;
            status_q     <= STATUS_NONE;
            exit_code_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            core_rst_n_q <= core_rst_n_d;
            fetch_en_q   <= fetch_en_d;
            cycle_cnt_q  <= cycle_cnt_d;
            status_q     <= status_d;
            exit_code_q  <= exit_code_d;
            done_q       <= done_d;
        end
    end

    assign core_rst_no    = core_rst_n_q;
    assign fetch_enable_o = fetch_en_q;
    assign cycle_cnt_o    = cycle_cnt_q;
    assign status_o       = status_q;
    assign exit_code_o    = exit_code_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_tb_sim_ctrl.sv
// Self-checking bench for tb_sim_ctrl: directed and randomized runs against a
// behavioural model of the start-up timing and the terminating-event rules.
module tb_tb_sim_ctrl;

    localparam int RESET_HOLD = 16;
    localparam int FETCH_DLY  = 4;
    localparam int DRAIN      = 8;

    localparam logic [2:0] S_NONE     = 3'd0;
    localparam logic [2:0] S_PASS     = 3'd1;
    localparam logic [2:0] S_FAIL     = 3'd2;
    localparam logic [2:0] S_EXIT_OK  = 3'd3;
    localparam logic [2:0] S_EXIT_ERR = 3'd4;
    localparam logic [2:0] S_TIMEOUT  = 3'd5;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] max_cycles_i;
    logic        tests_passed_i;
    logic        tests_failed_i;
    logic        exit_valid_i;
    logic [31:0] exit_value_i;
    logic        core_rst_no;
    logic        fetch_enable_o;
    logic [31:0] cycle_cnt_o;
    logic [2:0]  status_o;
    logic [31:0] exit_code_o;
    logic        done_o;

    int vectors     = 0;
    int miscompares = 0;

    tb_sim_ctrl dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .max_cycles_i   (max_cycles_i),
        .tests_passed_i (tests_passed_i),
        .tests_failed_i (tests_failed_i),
        .exit_valid_i   (exit_valid_i),
        .exit_value_i   (exit_value_i),
        .core_rst_no    (core_rst_no),
        .fetch_enable_o (fetch_enable_o),
        .cycle_cnt_o    (cycle_cnt_o),
        .status_o       (status_o),
        .exit_code_o    (exit_code_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Safety net in case the sequence stalls.
    initial begin
        #3_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "[TB] aborted");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic f, input logic p, input logic ev, input logic [31:0] val);
        tests_failed_i = f;
        tests_passed_i = p;
        exit_valid_i   = ev;
        exit_value_i   = val;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_core_rst"}, {31'd0, core_rst_no}, 32'd0);
        checkOutput({tag, "_fetch"},    {31'd0, fetch_enable_o}, 32'd0);
        checkOutput({tag, "_cnt"},      cycle_cnt_o, 32'd0);
        checkOutput({tag, "_status"},   {29'd0, status_o}, {29'd0, S_NONE});
        checkOutput({tag, "_code"},     exit_code_o, 32'd0);
        checkOutput({tag, "_done"},     {31'd0, done_o}, 32'd0);
    endtask

    // Drops reset between clock edges and checks outputs before any edge occurs.
    task automatic asyncReset(input string tag);
        #2;
        rst_ni = 1'b0;
        #1;
        checkResetValues(tag);
        #2;
        rst_ni = 1'b1;
        tick();
    endtask

    // Reference outcome of a terminating event, taken from the priority rules.
    function automatic void refOutcome(input logic f, input logic p, input logic ev,
                                       input logic [31:0] val,
                                       output logic [2:0] st, output logic [31:0] code);
        if (f) begin
            st = S_FAIL;      code = 32'd1;
        end else if (ev && val != 0) begin
            st = S_EXIT_ERR;  code = val;
        end else if (p) begin
            st = S_PASS;      code = 32'd0;
        end else begin
            st = S_EXIT_OK;   code = val;
        end
    endfunction

    // Start the sequence and check reset-hold and fetch-delay timing.
    task automatic startRun(input string tag);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (RESET_HOLD - 1) tick();
        checkOutput({tag, "_rst_held"}, {31'd0, core_rst_no}, 32'd0);
        tick();
        checkOutput({tag, "_rst_rel"}, {31'd0, core_rst_no}, 32'd1);
        repeat (FETCH_DLY - 1) tick();
        checkOutput({tag, "_fetch_wait"}, {31'd0, fetch_enable_o}, 32'd0);
        tick();
        checkOutput({tag, "_fetch_on"}, {31'd0, fetch_enable_o}, 32'd1);
        checkOutput({tag, "_cnt0"}, cycle_cnt_o, 32'd0);
    endtask

    // One complete run: events presented in RUN cycle k, optional watchdog limit.
    task automatic runScenario(input string tag, input int k, input logic f, input logic p,
                               input logic ev, input logic [31:0] val, input logic [31:0] maxc,
                               input bit pokeInDrain);
        logic [2:0]  expSt;
        logic [31:0] expCode;
        int          te;
        int          e;
        max_cycles_i = maxc;
        startRun(tag);
        te = (maxc != 0) ? int'(maxc) : 1_000_000;
        if ((f | p | ev) && k <= te) begin
            e = k;
            refOutcome(f, p, ev, val, expSt, expCode);
        end else begin
            e = te;
            expSt = S_TIMEOUT;
            expCode = 32'hFFFF_FFFF;
        end
        for (int c = 0; c <= e; c++) begin
            if (c == k) applyStimulus(f, p, ev, val);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        end
        checkOutput({tag, "_status"}, {29'd0, status_o}, {29'd0, expSt});
        checkOutput({tag, "_code"},   exit_code_o, expCode);
        checkOutput({tag, "_cnt"},    cycle_cnt_o, 32'(e));
        checkOutput({tag, "_fetch_off"}, {31'd0, fetch_enable_o}, 32'd0);
        for (int i = 1; i <= DRAIN; i++) begin
            if (pokeInDrain && i == 3) applyStimulus(1'b0, 1'b1, 1'b1, 32'h55);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
            if (i == DRAIN - 1) checkOutput({tag, "_drain"}, {31'd0, done_o}, 32'd0);
        end
        checkOutput({tag, "_done"}, {31'd0, done_o}, 32'd1);
        repeat (3) tick();
        checkOutput({tag, "_sticky"}, {31'd0, done_o}, 32'd1);
        checkOutput({tag, "_hold_status"}, {29'd0, status_o}, {29'd0, expSt});
        checkOutput({tag, "_hold_code"}, exit_code_o, expCode);
        checkOutput({tag, "_hold_rst"}, {31'd0, core_rst_no}, 32'd1);
        asyncReset({tag, "_rst"});
    endtask

    initial begin
        logic        f;
        logic        p;
        logic        ev;
        logic [31:0] val;
        logic [31:0] maxc;
        int          k;

        rst_ni = 1'b0;
        start_i = 1'b0;
        max_cycles_i = 32'd0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        #2;
        checkResetValues("por");
        #5;
        rst_ni = 1'b1;
        tick();

        // start_i held low: controller must stay idle.
        repeat (5) tick();
        checkOutput("idle_core_rst", {31'd0, core_rst_no}, 32'd0);

        runScenario("pass100",   100, 1'b0, 1'b1, 1'b0, 32'd0,  32'd0,  1'b0);
        runScenario("exit_err",  30,  1'b0, 1'b0, 1'b1, 32'h2A, 32'd0,  1'b0);
        runScenario("exit_ok",   12,  1'b0, 1'b0, 1'b1, 32'd0,  32'd0,  1'b0);
        runScenario("timeout50", 0,   1'b0, 1'b0, 1'b0, 32'd0,  32'd50, 1'b0);
        runScenario("all_same",  7,   1'b1, 1'b1, 1'b1, 32'h9,  32'd0,  1'b1);
        runScenario("ev_vs_wd",  20,  1'b0, 1'b1, 1'b0, 32'd0,  32'd20, 1'b0);
        runScenario("first_cyc", 0,   1'b0, 1'b0, 1'b1, 32'h3,  32'd0,  1'b0);

        // Watchdog disabled: 10k RUN cycles with no events, then reset mid-RUN.
        max_cycles_i = 32'd0;
        startRun("nowd");
        repeat (10000) tick();
        checkOutput("nowd_status", {29'd0, status_o}, {29'd0, S_NONE});
        checkOutput("nowd_cnt", cycle_cnt_o, 32'd10000);
        checkOutput("nowd_fetch", {31'd0, fetch_enable_o}, 32'd1);
        asyncReset("rst_run");

        // Reset mid-DRAIN.
        startRun("mid_drain");
        repeat (5) tick();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'd0);
        checkOutput("mid_drain_status", {29'd0, status_o}, {29'd0, S_PASS});
        repeat (3) tick();
        asyncReset("rst_drain");

        // Restart after reset completes normally.
        runScenario("restart", 15, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Randomized scenarios.
        for (int r = 0; r < 10; r++) begin
            k    = int'($urandom_range(0, 60));
            f    = ($urandom_range(0, 3) == 0);
            p    = ($urandom_range(0, 1) == 1);
            ev   = ($urandom_range(0, 1) == 1);
            val  = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
            maxc = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 80));
            if (!(f | p | ev) && maxc == 0) p = 1'b1;
            runScenario($sformatf("rnd%0d", r), k, f, p, ev, val, maxc, ($urandom_range(0, 1) == 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
